// File: rtl/tt_mux_ctrl_pkg.sv
// Shared types and helpers for the spine mux sequencer.
// Holds the state encoding, address width and the select-line mapping.
package tt_mux_ctrl_pkg;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_PARK   = 3'd0,
    ST_DROP   = 3'd1,
    ST_SWITCH = 3'd2,
    ST_URST   = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  // Design index {mux_addr, um_idx} -> row mux select wiring.
  function automatic logic [ADDR_W-1:0] sel_map(input logic [ADDR_W-1:0] addr);
    logic [4:0] a;
    logic [4:0] u;
    a = addr[9:5];
    u = addr[4:0];
    return {a[4:1], u[0], a[0], u[4:1]};
  endfunction

endpackage

// File: rtl/tt_mux_ctrl_timer.sv
// Loadable 8-bit down-counter shared by the timed sequencer phases.
// Holds at zero; done is high whenever the count is zero.
module tt_mux_ctrl_timer
  import tt_mux_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/tt_mux_ctrl.sv
// Spine mux sequencer: drops enable, changes select, re-enables, then
// releases the user reset so a user design switch never glitches the spine.
//
//   state  | meaning
//   PARK   | nothing selected, enable and user reset held low
//   DROP   | enable low, guard time before the select may move
//   SWITCH | new select driven, settling with enable low
//   URST   | enable high, user design still in reset
//   RUN    | user design enabled and out of reset
module tt_mux_ctrl
  import tt_mux_ctrl_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RST_CYCLES    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_off,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] spine_sel,
  output logic              spine_ena,
  output logic              um_rst_n,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              active,
  output logic              busy
);

  localparam logic [CNT_W-1:0] GUARD_LD  = 8'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD    = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_MAX   =
    (GUARD_LD > SETTLE_LD) ? ((GUARD_LD > RST_LD) ? GUARD_LD : RST_LD)
                           : ((SETTLE_LD > RST_LD) ? SETTLE_LD : RST_LD);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              off_q;
  logic              busy_q;
  logic              ready_q;
  logic [ADDR_W-1:0] sel_q;
  logic [ADDR_W-1:0] cur_q;
  logic              ena_q;
  logic              rstn_q;
  logic              active_q;

  logic              accept;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_done;

  assign accept = req_valid & ready_q;

  // Timer reload happens on the same edge the FSM enters a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_PARK: begin
        if (accept && !req_off) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_RUN: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = GUARD_LD;
        end
      end
      ST_DROP: begin
        if (tmr_done && !off_q) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_SWITCH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = RST_LD;
        end
      end
      default: begin
      end
    endcase
  end

  tt_mux_ctrl_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PARK;
      addr_q  <= '0;
      off_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_PARK: begin
          // An off request while parked is accepted and ignored.
          if (accept && !req_off) begin
            state_q <= ST_SWITCH;
            addr_q  <= req_addr;
            off_q   <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            state_q <= ST_DROP;
            off_q   <= req_off;
            if (!req_off) addr_q <= req_addr;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_DROP: begin
          if (tmr_done) begin
            if (off_q) begin
              state_q <= ST_PARK;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_SWITCH;
            end
          end
        end
        ST_SWITCH: begin
          if (tmr_done) state_q <= ST_URST;
        end
        ST_URST: begin
          if (tmr_done) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_PARK;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Spine-facing bits are a registered decode of the state, one edge behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      cur_q    <= '0;
      ena_q    <= 1'b0;
      rstn_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      ena_q    <= (state_q == ST_URST) || (state_q == ST_RUN);
      rstn_q   <= (state_q == ST_RUN);
      active_q <= (state_q == ST_RUN);
      if (state_q == ST_SWITCH) begin
        sel_q <= sel_map(addr_q);
        cur_q <= addr_q;
      end
    end
  end

  assign spine_sel = sel_q;
  assign cur_addr  = cur_q;
  assign spine_ena = ena_q;
  assign um_rst_n  = rstn_q;
  assign active    = active_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;

  a_sel_quiet: assert property (@(posedge clk) disable iff (rst)
    !$stable(sel_q) |-> (!ena_q && !$past(ena_q)));

  a_rstn_ena: assert property (@(posedge clk) disable iff (rst)
    rstn_q |-> ena_q);

  a_busy_state: assert property (@(posedge clk) disable iff (rst)
    busy_q == !(state_q inside {ST_PARK, ST_RUN}));

  a_ready_busy: assert property (@(posedge clk) disable iff (rst)
    ready_q == !busy_q);

  a_tmr_range: assert property (@(posedge clk) disable iff (rst)
    tmr_value <= TMR_MAX);

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Directed bench for the spine mux sequencer with default timing (G=4, S=4, R=8).
// Expected select values are the hand-mapped spine_sel of each design index.
module tb_tt_mux_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_off = 1'b0;
  logic [9:0] req_addr = 10'h000;
  logic       req_ready;
  logic [9:0] spine_sel;
  logic       spine_ena;
  logic       um_rst_n;
  logic [9:0] cur_addr;
  logic       active;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // 0x2A3: A=0x15 U=0x03 -> 1010_1_1_0001
  localparam logic [9:0] SEL_2A3 = 10'h2B1;
  // 0x041: A=0x02 U=0x01 -> 0001_1_0_0000
  localparam logic [9:0] SEL_041 = 10'h060;
  // 0x155: A=0x0A U=0x15 -> 0101_1_0_1010
  localparam logic [9:0] SEL_155 = 10'h16A;

  always #5 clk = ~clk;

  tt_mux_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_off   (req_off),
    .req_addr  (req_addr),
    .spine_sel (spine_sel),
    .spine_ena (spine_ena),
    .um_rst_n  (um_rst_n),
    .cur_addr  (cur_addr),
    .active    (active),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the falling edge after the acceptance edge (edge 0).
  task automatic send(input logic off, input logic [9:0] addr);
    @(negedge clk);
    req_valid = 1'b1;
    req_off   = off;
    req_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {spine_sel, cur_addr, spine_ena, um_rst_n, active, busy, req_ready};
    total++;
    if (obs !== {10'h000, 10'h000, 5'b00001}) begin
      bad++;
      $display("FAIL reset_held got=%h exp=%h", obs, {10'h000, 10'h000, 5'b00001});
    end
    rst = 1'b0;
    @(negedge clk);
    obs = {spine_sel, cur_addr, spine_ena, um_rst_n, active, busy, req_ready};
    total++;
    if (obs !== {10'h000, 10'h000, 5'b00001}) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", obs, {10'h000, 10'h000, 5'b00001});
    end
  endtask

  task automatic test_park_select();
    logic [22:0] obs, exp;
    send(1'b0, 10'h2A3);
    for (int k = 1; k <= 13; k++) begin
      step();
      obs = {spine_sel, cur_addr, spine_ena, um_rst_n, active};
      exp = {SEL_2A3, 10'h2A3, (k >= 5), (k >= 13), (k >= 13)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL park_select edge=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k <= 11 || k == 13) begin
        total++;
        if ({busy, req_ready} !== {(k <= 11), (k == 13)}) begin
          bad++;
          $display("FAIL park_select_busy edge=%0d got=%b%b exp=%b%b", k, busy, req_ready, (k <= 11), (k == 13));
        end
      end
    end
  endtask

  task automatic test_switch_running();
    logic [22:0] obs, exp;
    send(1'b0, 10'h041);
    for (int k = 1; k <= 17; k++) begin
      step();
      obs = {spine_sel, cur_addr, spine_ena, um_rst_n, active};
      exp = {(k >= 5) ? SEL_041 : SEL_2A3, (k >= 5) ? 10'h041 : 10'h2A3,
             (k >= 9), (k >= 17), (k >= 17)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL switch_run edge=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k <= 15 || k == 17) begin
        total++;
        if ({busy, req_ready} !== {(k <= 15), (k == 17)}) begin
          bad++;
          $display("FAIL switch_run_busy edge=%0d got=%b%b exp=%b%b", k, busy, req_ready, (k <= 15), (k == 17));
        end
      end
    end
  endtask

  task automatic test_same_addr();
    logic [22:0] obs, exp;
    int low_cnt = 0;
    send(1'b0, 10'h041);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (!um_rst_n) low_cnt++;
      obs = {spine_sel, cur_addr, spine_ena, um_rst_n, active};
      exp = {SEL_041, 10'h041, (k >= 9), (k >= 17), (k >= 17)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL same_addr edge=%0d got=%h exp=%h", k, obs, exp);
      end
    end
    total++;
    if (low_cnt != 16) begin
      bad++;
      $display("FAIL same_addr_rst_low got=%0d exp=16", low_cnt);
    end
  endtask

  task automatic test_off();
    logic [22:0] obs, exp;
    send(1'b1, 10'h3FF);
    for (int k = 1; k <= 6; k++) begin
      step();
      obs = {spine_sel, cur_addr, spine_ena, um_rst_n, active};
      exp = {SEL_041, 10'h041, 3'b000};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL off_run edge=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k <= 3 || k >= 5) begin
        total++;
        if ({busy, req_ready} !== {(k <= 3), (k >= 5)}) begin
          bad++;
          $display("FAIL off_run_busy edge=%0d got=%b%b exp=%b%b", k, busy, req_ready, (k <= 3), (k >= 5));
        end
      end
    end
    send(1'b1, 10'h155);
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if ({spine_sel, cur_addr, spine_ena, um_rst_n, active, busy, req_ready} !==
          {SEL_041, 10'h041, 5'b00001}) begin
        bad++;
        $display("FAIL off_park edge=%0d got=%h exp=%h", k,
                 {spine_sel, cur_addr, spine_ena, um_rst_n, active, busy, req_ready},
                 {SEL_041, 10'h041, 5'b00001});
      end
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    logic saw_low;
    @(negedge clk);
    req_valid = 1'b1;
    req_off   = 1'b0;
    req_addr  = 10'h2A3;
    @(posedge clk);
    @(negedge clk);
    req_addr = 10'h041;
    for (int k = 1; k <= 11; k++) begin
      step();
      total++;
      if ({req_ready, cur_addr} !== {1'b0, 10'h2A3}) begin
        bad++;
        $display("FAIL b2b_hold edge=%0d got=%b/%h exp=0/2a3", k, req_ready, cur_addr);
      end
    end
    n = 0;
    while (!req_ready && n < 5) begin
      step();
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL b2b_ready_timeout got=%b exp=1", req_ready);
    end
    n = 0;
    while (!busy && n < 4) begin
      step();
      n++;
    end
    req_valid = 1'b0;
    total++;
    if ({busy, active, cur_addr} !== {2'b11, 10'h2A3}) begin
      bad++;
      $display("FAIL b2b_accept got=%b%b/%h exp=11/2a3", busy, active, cur_addr);
    end
    n = 0;
    while (spine_ena && n < 4) begin
      step();
      n++;
    end
    saw_low = !spine_ena;
    n = 0;
    while (!um_rst_n && n < 25) begin
      step();
      n++;
    end
    total++;
    if ({saw_low, um_rst_n, spine_sel, cur_addr} !== {2'b11, SEL_041, 10'h041}) begin
      bad++;
      $display("FAIL b2b_second got=%b%b/%h/%h exp=11/%h/041", saw_low, um_rst_n, spine_sel, cur_addr, SEL_041);
    end
  endtask

  task automatic test_async_reset();
    send(1'b0, 10'h155);
    repeat (6) step();
    total++;
    if ({spine_sel, spine_ena, busy} !== {SEL_155, 2'b01}) begin
      bad++;
      $display("FAIL areset_pre got=%h/%b%b exp=%h/01", spine_sel, spine_ena, busy, SEL_155);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({spine_sel, cur_addr, spine_ena, um_rst_n, active, busy, req_ready} !==
        {10'h000, 10'h000, 5'b00001}) begin
      bad++;
      $display("FAIL areset_now got=%h exp=%h",
               {spine_sel, cur_addr, spine_ena, um_rst_n, active, busy, req_ready},
               {10'h000, 10'h000, 5'b00001});
    end
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 10'h2A3);
    step();
    total++;
    if ({spine_sel, spine_ena, busy} !== {SEL_2A3, 2'b01}) begin
      bad++;
      $display("FAIL areset_restart got=%h/%b%b exp=%h/01", spine_sel, spine_ena, busy, SEL_2A3);
    end
    repeat (12) step();
    total++;
    if ({spine_ena, um_rst_n, active, cur_addr} !== {3'b111, 10'h2A3}) begin
      bad++;
      $display("FAIL areset_run got=%b%b%b/%h exp=111/2a3", spine_ena, um_rst_n, active, cur_addr);
    end
  endtask

  initial begin
    test_reset();
    test_park_select();
    test_switch_running();
    test_same_addr();
    test_off();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
